// File: rtl/mac48_pkg.sv
// Shared widths and the round/shift/saturate helper for the MAC48 result path.
package mac48_pkg;
    localparam int P_W   = 48;
    localparam int ACC_W = 52;

    typedef struct packed {
        logic [31:0] val;
        logic        sat;
    } rsat_t;

    // Round half-up, arithmetic shift, then clamp to an out_w-bit signed range.
    function automatic rsat_t round_sat(input logic signed [ACC_W-1:0] sum,
                                        input int shift, input int out_w);
        logic signed [ACC_W:0] t;
        logic signed [ACC_W:0] hi;
        logic signed [ACC_W:0] lo;
        rsat_t res;
        t  = {sum[ACC_W-1], sum} + ((ACC_W+1)'(1) << (shift - 1));
        t  = t >>> shift;
        hi = ((ACC_W+1)'(1) << (out_w - 1)) - (ACC_W+1)'(1);
        lo = -hi - (ACC_W+1)'(1);
        res.sat = 1'b0;
        res.val = t[31:0];
        if (t > hi) begin
            res.val = hi[31:0];
            res.sat = 1'b1;
        end else if (t < lo) begin
            res.val = lo[31:0];
            res.sat = 1'b1;
        end
        return res;
    endfunction
endpackage

// File: rtl/sync_fifo2.sv
// Generic 2-entry valid/ready buffer; accepts a push while full if a pop happens that cycle.
module sync_fifo2 #(
    parameter int W = 8
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    logic [1:0]   n;
    logic [W-1:0] h, s;
    logic         push, pop;

    assign out_vld = (n != 2'd0);
    assign out_dat = h;
    assign in_rdy  = (n != 2'd2) | out_rdy;
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            n <= 2'd0;
            h <= '0;
            s <= '0;
        end else begin
            case (n)
                2'd0: if (push) begin
                    h <= in_dat;
                    n <= 2'd1;
                end
                2'd1: case ({push, pop})
                    2'b10: begin s <= in_dat; n <= 2'd2; end
                    2'b11: h <= in_dat;
                    2'b01: n <= 2'd0;
                    default: ;
                endcase
                default: if (pop) begin
                    h <= s;
                    if (push) s <= in_dat;
                    else      n <= 2'd1;
                end
            endcase
        end
    end
endmodule

// File: rtl/mac48_result_rx.sv
// Receive end of the 18x18/48-bit MAC cascade: strobe delay, multi-pass accumulate,
// round/saturate and a 2-entry output buffer.
module mac48_result_rx
    import mac48_pkg::*;
#(
    parameter int LATENCY = 6,
    parameter int NPASS   = 1,
    parameter int SHIFT   = 16,
    parameter int OUT_W   = 18
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    CE,
    input  logic                    STB,
    input  logic                    SOG,
    input  logic signed [P_W-1:0]   P,
    output logic signed [OUT_W-1:0] Q,
    output logic                    QV,
    input  logic                    QR,
    output logic                    OVF,
    output logic                    DROP,
    output logic                    SEQERR,
    input  logic                    CLR
);
    localparam int CW = $clog2(NPASS + 1);

    logic [LATENCY:1][1:0]   dl;
    logic                    pv, psog, take, start, restart, fin;
    logic signed [ACC_W-1:0] acc, pext, sum;
    logic [CW-1:0]           cnt, cnt_take;
    rsat_t                   rs;
    logic                    in_rdy, unused_hi;
    logic [OUT_W-1:0]        qd;

    // Delay line bit 1 = strobe, bit 0 = start-of-group, both aligned with P at the tap.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) dl <= '0;
        else if (CE) begin
            dl[1] <= {STB, STB & SOG};
            for (int i = 2; i <= LATENCY; i++) dl[i] <= dl[i-1];
        end
    end

    assign pv   = dl[LATENCY][1];
    assign psog = dl[LATENCY][0];
    assign take = CE & pv;
    assign pext = {{(ACC_W-P_W){P[P_W-1]}}, P};

    always_comb begin
        start    = (cnt == '0) | psog;
        restart  = psog & (cnt != '0);
        sum      = start ? pext : acc + pext;
        cnt_take = start ? CW'(1) : cnt + CW'(1);
        fin      = take & (cnt_take == CW'(NPASS));
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            acc <= '0;
            cnt <= '0;
        end else if (take) begin
            if (cnt_take == CW'(NPASS)) cnt <= '0;
            else begin
                cnt <= cnt_take;
                acc <= sum;
            end
        end
    end

    // The buffer entry itself is the round-stage register.
    assign rs        = round_sat(sum, SHIFT, OUT_W);
    assign qd        = rs.val[OUT_W-1:0];
    assign unused_hi = ^rs.val;

    sync_fifo2 #(.W(OUT_W)) u_buf (
        .gclk    (CLK),
        .grst_n  (RSTN),
        .in_vld  (fin),
        .in_rdy  (in_rdy),
        .in_dat  (qd),
        .out_vld (QV),
        .out_rdy (QR),
        .out_dat (Q)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            OVF    <= 1'b0;
            DROP   <= 1'b0;
            SEQERR <= 1'b0;
        end else begin
            OVF    <= (fin & rs.sat) | (OVF & ~CLR);
            DROP   <= (fin & ~in_rdy) | (DROP & ~CLR);
            SEQERR <= (take & restart) | (SEQERR & ~CLR);
        end
    end
endmodule

// File: tb/tb_mac48_result_rx.sv
// Directed bench for mac48_result_rx: one NPASS=1 and one NPASS=4 instance on shared stimulus.
module tb_mac48_result_rx;
    logic        CLK = 1'b0;
    logic        RSTN = 1'b0, CE = 1'b1, STB = 1'b0, SOG = 1'b0, QR = 1'b1, CLR = 1'b0;
    logic [47:0] P, pnext = '0;
    logic [47:0] pq [1:6];
    logic [17:0] Q1, Q4;
    logic        QV1, OVF1, DROP1, SEQ1, QV4, OVF4, DROP4, SEQ4;
    int          n_run = 0, n_fail = 0, cyc = 0;

    always #5 CLK = ~CLK;

    // Cascade model: P follows the operand strobe by 6 CE-qualified cycles.
    always @(posedge CLK) if (CE) begin
        pq[1] <= pnext;
        for (int i = 2; i <= 6; i++) pq[i] <= pq[i-1];
    end
    assign P = pq[6];

    mac48_result_rx #(.LATENCY(6), .NPASS(1), .SHIFT(16), .OUT_W(18)) u1 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE), .STB(STB), .SOG(SOG), .P(P),
        .Q(Q1), .QV(QV1), .QR(QR), .OVF(OVF1), .DROP(DROP1), .SEQERR(SEQ1), .CLR(CLR));

    mac48_result_rx #(.LATENCY(6), .NPASS(4), .SHIFT(16), .OUT_W(18)) u4 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE), .STB(STB), .SOG(SOG), .P(P),
        .Q(Q4), .QV(QV4), .QR(QR), .OVF(OVF4), .DROP(DROP4), .SEQERR(SEQ4), .CLR(CLR));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic strobe(input logic sog, input logic [47:0] v);
        STB = 1'b1; SOG = sog; pnext = v;
        tick();
        STB = 1'b0; SOG = 1'b0;
    endtask

    task automatic do_reset;
        RSTN = 1'b0;
        tick(); tick();
        RSTN = 1'b1;
        tick();
    endtask

    task automatic wait4(output int at);
        int k = 0;
        while (!QV4 && k < 40) begin tick(); k++; end
        if (!QV4) chk("qv4_timeout", 64'd0, 64'd1);
        at = cyc;
    endtask

    initial begin
        int c0, at, nq;
        logic [17:0] qcap;

        #1;
        chk("rst_q",    {46'd0, Q1}, 64'd0);
        chk("rst_qv",   {63'd0, QV1}, 64'd0);
        chk("rst_flags", {61'd0, OVF1, DROP1, SEQ1}, 64'd0);
        do_reset();

        // NPASS=1 latency and rounding
        c0 = cyc;
        strobe(1'b0, 48'h000000018000);
        repeat (5) tick();
        chk("lat_early", {63'd0, QV1}, 64'd0);
        tick();
        chk("lat_qv",  {63'd0, QV1}, 64'd1);
        chk("lat_cyc", 64'(cyc - c0), 64'd7);
        chk("q_pos",   {46'd0, Q1}, 64'h2);
        chk("ovf_0",   {63'd0, OVF1}, 64'd0);

        strobe(1'b0, 48'hFFFFFFFE8000);
        repeat (6) tick();
        chk("q_neg",   {46'd0, Q1}, 64'h3FFFF);
        chk("ovf_neg", {63'd0, OVF1}, 64'd0);

        strobe(1'b0, 48'h000200000000);
        repeat (6) tick();
        chk("q_satp",  {46'd0, Q1}, 64'h1FFFF);
        chk("ovf_p",   {63'd0, OVF1}, 64'd1);

        strobe(1'b0, 48'hFFFDFFFF0000);
        repeat (6) tick();
        chk("q_satn",  {46'd0, Q1}, 64'h20000);
        chk("ovf_n",   {63'd0, OVF1}, 64'd1);

        CLR = 1'b1; tick(); CLR = 1'b0;
        chk("ovf_clr", {63'd0, OVF1}, 64'd0);

        // NPASS=4 back-to-back group, then with a 3-cycle CE gap
        do_reset();
        c0 = cyc;
        strobe(1'b1, 48'h10000);
        repeat (3) strobe(1'b0, 48'h10000);
        wait4(at);
        chk("np4_lat", 64'(at - c0), 64'd10);
        chk("np4_q",   {46'd0, Q4}, 64'd4);
        tick();
        chk("np4_pulse", {63'd0, QV4}, 64'd0);

        c0 = cyc;
        strobe(1'b1, 48'h10000);
        strobe(1'b0, 48'h10000);
        CE = 1'b0;
        repeat (3) tick();
        CE = 1'b1;
        strobe(1'b0, 48'h10000);
        strobe(1'b0, 48'h10000);
        wait4(at);
        chk("ce_lat", 64'(at - c0), 64'd13);
        chk("ce_q",   {46'd0, Q4}, 64'd4);

        // SOG mid-group restarts the sum and flags it
        do_reset();
        strobe(1'b1, 48'h10000);
        strobe(1'b0, 48'h10000);
        strobe(1'b1, 48'h10000);
        repeat (3) strobe(1'b0, 48'h10000);
        nq = 0; qcap = '0;
        repeat (20) begin
            if (QV4) begin nq++; qcap = Q4; end
            tick();
        end
        chk("seq_nout", 64'(nq), 64'd1);
        chk("seq_q",    {46'd0, qcap}, 64'd4);
        chk("seq_flag", {63'd0, SEQ4}, 64'd1);
        chk("seq_np1",  {63'd0, SEQ1}, 64'd0);

        // Backpressure: third result lost
        do_reset();
        QR = 1'b0;
        strobe(1'b0, 48'h10000);
        strobe(1'b0, 48'h20000);
        strobe(1'b0, 48'h30000);
        repeat (10) tick();
        chk("bp_qv",   {63'd0, QV1}, 64'd1);
        chk("bp_q1",   {46'd0, Q1}, 64'd1);
        chk("bp_drop", {63'd0, DROP1}, 64'd1);
        QR = 1'b1;
        tick();
        chk("bp_qv2",  {63'd0, QV1}, 64'd1);
        chk("bp_q2",   {46'd0, Q1}, 64'd2);
        tick();
        chk("bp_empty", {63'd0, QV1}, 64'd0);

        // Async reset mid-group with buffered data and flags set
        do_reset();
        QR = 1'b0;
        strobe(1'b1, 48'h000200000000);
        strobe(1'b0, 48'h10000);
        strobe(1'b1, 48'h10000);
        strobe(1'b0, 48'h10000);
        repeat (8) tick();
        chk("pre_qv",   {63'd0, QV1}, 64'd1);
        chk("pre_flags", {61'd0, OVF1, DROP1, SEQ4}, 64'h7);
        RSTN = 1'b0;
        #1;
        chk("ar_qv",    {63'd0, QV1}, 64'd0);
        chk("ar_q",     {46'd0, Q1}, 64'd0);
        chk("ar_flags", {61'd0, OVF1, DROP1, SEQ4}, 64'd0);
        tick();
        RSTN = 1'b1;
        QR = 1'b1;
        tick();
        strobe(1'b1, 48'h10000);
        repeat (3) strobe(1'b0, 48'h10000);
        wait4(at);
        chk("post_q",   {46'd0, Q4}, 64'd4);
        chk("post_seq", {63'd0, SEQ4}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mac48_result_rx.md
Name: mac48_result_rx

Overview:
Receive end of the quad 18x18 multiply / 48-bit add cascade used by the systolic FIR filters. Tracks which sum-of-products outputs are valid by delaying a strobe issued alongside the multiplier operands. Optionally accumulates several consecutive 48-bit sums, for filters longer than one cascade. Rounds, shifts and saturates each result to the filter output width, then hands it downstream through a 2-entry valid/ready buffer.

Parameters:
LATENCY, 6, CE-qualified cycles from operands at the cascade input to the matching P (1..15)
NPASS, 1, cascade sums accumulated per output sample (1..16)
SHIFT, 16, right shift applied after rounding (1..40)
OUT_W, 18, signed output width (8..32)

Ports:
CLK  in  1  clock, all logic rising-edge
RSTN  in  1  asynchronous active-low reset
CE  in  1  clock enable, same signal that drives the cascade CE
STB  in  1  operands valid at cascade A/B inputs this cycle
SOG  in  1  start of group; qualified by STB; first pass of an output sample
P  in  48  signed cascade sum
Q  out  OUT_W  signed rounded/saturated result
QV  out  1  Q valid
QR  in  1  downstream ready
OVF  out  1  sticky: a result saturated
DROP  out  1  sticky: a result was lost to a full buffer
SEQERR  out  1  sticky: SOG arrived mid-group
CLR  in  1  synchronous clear of the sticky flags

Behaviour:
- Reset (RSTN=0, async): delay line, accumulator, pass counter and buffer cleared. Outputs on reset: Q=0, QV=0, OVF=0, DROP=0, SEQERR=0.
- Delay line: LATENCY-deep shift register of {STB, STB&SOG}.
  - Shifts only when CE=1.
  - The tap gives PV/PSOG aligned with P. P is sampled only when PV=1 and CE=1.
  - With CE=0, the delay line, accumulator and counter hold their state.
- Accumulator: signed, 52 bits; P is sign-extended into it. Counter cnt runs 0..NPASS-1. On each valid P:
  - cnt==0: acc=P, cnt=1. PSOG may be either value.
  - cnt!=0 and PSOG=1: discard the partial sum, set acc=P and cnt=1, set SEQERR.
  - Otherwise: acc=acc+P, cnt=cnt+1.
  - When the pass just taken completes NPASS passes: the final sum (acc+P, or P if NPASS=1) goes to the round stage, and cnt=0.
- Round stage (registered, 1 cycle):
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift.
  - If r exceeds the OUT_W signed range, clamp to +max or -min and set OVF.
  - Next cycle the result is pushed to the buffer.
  - Latency: final valid P at cycle n gives QV=1 at cycle n+1, provided the buffer was empty.
- Output buffer: 2-entry FIFO.
  - QV = not empty; Q = head entry. Pop when QV&QR.
  - Push when full with no pop in the same cycle: the new result is discarded, DROP is set, stored entries are unchanged.
  - Push and pop in the same cycle while full: both succeed.
  - The buffer runs independently of CE.
- Sticky flags: CLR=1 clears them next cycle. If a set event and CLR occur in the same cycle, the set wins.
- NPASS=1 makes SOG irrelevant. SEQERR can never set.

Decomposition:
- Shared package mac48_pkg:
  - constants P_W=48 and ACC_W=52.
  - function round_sat(sum, SHIFT, OUT_W) returning {value, sat_flag}.
- One sub-module: sync_fifo2, a generic 2-entry valid/ready buffer, parameterised by width. Same async active-low reset.

Test Plan:
- LATENCY=6, NPASS=1, SHIFT=16, OUT_W=18, QR=1. STB at cycle 0, CE always 1, P=0x000000018000 at cycle 6 → QV=1 at cycle 7, Q=2, OVF=0.
- P=-0x18000 → Q=0x3FFFF (-1). P=0x000200000000 → Q=0x1FFFF, OVF=1. P=-0x000200010000 → Q=0x20000, OVF=1. Then CLR → OVF=0 next cycle.
- NPASS=4: four STB with SOG on the first, each P=0x10000 → a single QV pulse, Q=4. Insert CE=0 for 3 cycles between strobes → same Q, with QV delayed by exactly 3 cycles.
- NPASS=4: SOG, STB, then SOG again before the group ends → SEQERR=1. The following 4 passes of 0x10000 give Q=4. The partial group produces no output.
- QR=0 while three results arrive (Q=1,2,3) → two held, DROP=1. Raise QR → Q=1 then 2, QV=0 afterwards.
- Assert RSTN=0 mid-group with data in the buffer → QV=0 and all flags 0 immediately. The next full group produces a correct Q.
